// File: rtl/pulse_sync_pkg.sv
// pulse_sync_pkg: shared definitions for the toggle-based pulse crossing.
//   SYNC_STAGES_DEF : default synchroniser depth
//   pulse_state_e   : receive-side occupancy state (IDLE / PENDING / FULL)
//   capacity()      : number of events a CNT_W-bit pending counter can hold
package pulse_sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FULL    = 2'd2
  } pulse_state_e;

  // Saturation point of the pending counter: all-ones of cnt_w bits.
  function automatic int capacity(input int cnt_w);
    return (32'sd1 <<< cnt_w) - 32'sd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: N-flop single-bit synchroniser with asynchronous active-low reset.
// Also used on the sender side for the acknowledge path.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input bit
//   q     : synchronised output (last stage)
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain_r;

  // Shift the asynchronous bit through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {N{1'b0}};
    end else begin
      chain_r <= {chain_r[N-2:0], d};
    end
  end

  assign q = chain_r[N-1];

endmodule

// File: rtl/pulse_sync_rx.sv
// pulse_sync_rx: receive end of a toggle-based pulse crossing (clk_b domain).
// Each edge of toggle_i becomes one event held in a saturating pending counter
// and offered to a consumer over valid/ready; an acknowledge toggle goes back.
//   clk_b        : receive clock
//   rstn_b       : asynchronous active-low reset
//   toggle_i     : request toggle from the sender (asynchronous)
//   ack_toggle_o : acknowledge toggle to the sender (registered)
//   pulseB_o     : event valid, high while events are pending
//   ready_i      : consumer accept
//   pend_cnt_o   : number of pending events
//   overflow_o   : sticky lost-event flag
//   clr_ovf_i    : synchronous clear of overflow_o
module pulse_sync_rx
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int CNT_W         = 2,
  parameter bit ACK_ON_ACCEPT = 1'b1
) (
  input  logic             clk_b,
  input  logic             rstn_b,
  input  logic             toggle_i,
  output logic             ack_toggle_o,
  output logic             pulseB_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] pend_cnt_o,
  output logic             overflow_o,
  input  logic             clr_ovf_i
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(capacity(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             sync_q_s;
  logic             sync_d_r;
  logic             ev_s;
  logic             acc_s;
  logic             sat_s;
  logic             lost_s;
  logic             ack_flip_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  pulse_state_e     state_nxt_s;
  logic             valid_r;
  logic             ovf_r;
  logic             ack_r;

  sync_bit #(.N(SYNC_STAGES)) u_sync (
    .clk   (clk_b),
    .rst_n (rstn_b),
    .d     (toggle_i),
    .q     (sync_q_s)
  );

  // A level change between the last sync stage and its delayed copy is one event.
  assign ev_s   = sync_q_s ^ sync_d_r;
  assign acc_s  = valid_r & ready_i;
  assign sat_s  = (cnt_r == CNT_MAX);
  assign lost_s = ev_s & ~acc_s & sat_s;

  // Next pending count: arrival and accept on the same edge cancel out.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({ev_s, acc_s})
      2'b10: begin
        if (sat_s) begin
          cnt_nxt_s = cnt_r;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Occupancy state of the next count; valid is registered from it.
  always_comb begin
    state_nxt_s = PENDING;
    if (cnt_nxt_s == CNT_ZERO) begin
      state_nxt_s = IDLE;
    end else if (cnt_nxt_s == CNT_MAX) begin
      state_nxt_s = FULL;
    end else begin
      state_nxt_s = PENDING;
    end
  end

  // Choose which edge flips the acknowledge toggle.
  always_comb begin
    ack_flip_s = 1'b0;
    if (ACK_ON_ACCEPT) begin
      ack_flip_s = acc_s;
    end else begin
      ack_flip_s = ev_s;
    end
  end

  // Edge-detect copy, counter, valid, sticky overflow and acknowledge toggle.
  always_ff @(posedge clk_b or negedge rstn_b) begin
    if (!rstn_b) begin
      sync_d_r <= 1'b0;
      cnt_r    <= CNT_ZERO;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      ack_r    <= 1'b0;
    end else begin
      sync_d_r <= sync_q_s;
      cnt_r    <= cnt_nxt_s;
      valid_r  <= (state_nxt_s != IDLE);
      // A lost event takes priority over a coincident clear.
      if (lost_s) begin
        ovf_r <= 1'b1;
      end else if (clr_ovf_i) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
      ack_r <= ack_r ^ ack_flip_s;
    end
  end

  assign pend_cnt_o   = cnt_r;
  assign pulseB_o     = valid_r;
  assign overflow_o   = ovf_r;
  assign ack_toggle_o = ack_r;

endmodule

// File: tb/tb_pulse_sync_rx.sv
// tb_pulse_sync_rx: directed bench for pulse_sync_rx. Two instances share all
// inputs; dut_a acks on accept, dut_d acks on event detection.
module tb_pulse_sync_rx;

  logic       clk_b;
  logic       rstn_b;
  logic       toggle_i;
  logic       ready_i;
  logic       clr_ovf_i;
  logic       ack_a, pulse_a, ovf_a;
  logic       ack_d, pulse_d, ovf_d;
  logic [1:0] cnt_a, cnt_d;

  int n_total = 0;
  int n_bad   = 0;

  pulse_sync_rx #(.SYNC_STAGES(2), .CNT_W(2), .ACK_ON_ACCEPT(1'b1)) dut_a (
    .clk_b        (clk_b),
    .rstn_b       (rstn_b),
    .toggle_i     (toggle_i),
    .ack_toggle_o (ack_a),
    .pulseB_o     (pulse_a),
    .ready_i      (ready_i),
    .pend_cnt_o   (cnt_a),
    .overflow_o   (ovf_a),
    .clr_ovf_i    (clr_ovf_i)
  );

  pulse_sync_rx #(.SYNC_STAGES(2), .CNT_W(2), .ACK_ON_ACCEPT(1'b0)) dut_d (
    .clk_b        (clk_b),
    .rstn_b       (rstn_b),
    .toggle_i     (toggle_i),
    .ack_toggle_o (ack_d),
    .pulseB_o     (pulse_d),
    .ready_i      (ready_i),
    .pend_cnt_o   (cnt_d),
    .overflow_o   (ovf_d),
    .clr_ovf_i    (clr_ovf_i)
  );

  // Free-running receive clock, 10 time-unit period.
  initial begin
    clk_b = 1'b0;
    forever #5 clk_b = ~clk_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample just after it.
  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  // Directed scenario sequence.
  initial begin
    rstn_b    = 1'b0;
    toggle_i  = 1'b0;
    ready_i   = 1'b0;
    clr_ovf_i = 1'b0;
    #12;
    chk("rst_pulse", pulse_a, 0);
    chk("rst_cnt",   cnt_a,   0);
    chk("rst_ovf",   ovf_a,   0);
    chk("rst_ack_a", ack_a,   0);
    chk("rst_ack_d", ack_d,   0);
    @(negedge clk_b);
    rstn_b = 1'b1;
    tick();

    // 1: single toggle, ready held high
    ready_i  = 1'b1;
    toggle_i = 1'b1;
    tick(); chk("t1_e1_pulse", pulse_a, 0);
    tick(); chk("t1_e2_pulse", pulse_a, 0);
    tick();
    chk("t1_e3_pulse", pulse_a, 1);
    chk("t1_e3_cnt",   cnt_a,   1);
    chk("t1_e3_ack_a", ack_a,   0);
    chk("t1_e3_ack_d", ack_d,   1);
    tick();
    chk("t1_e4_pulse", pulse_a, 0);
    chk("t1_e4_cnt",   cnt_a,   0);
    chk("t1_e4_ack_a", ack_a,   1);
    tick();
    chk("t1_e5_pulse", pulse_a, 0);
    chk("t1_e5_ack_a", ack_a,   1);

    // 2: backpressure, three events
    ready_i  = 1'b0;
    toggle_i = 1'b0; repeat (4) tick(); chk("t2_cnt1", cnt_a, 1);
    toggle_i = 1'b1; repeat (4) tick(); chk("t2_cnt2", cnt_a, 2);
    toggle_i = 1'b0; repeat (4) tick();
    chk("t2_cnt3",   cnt_a,   3);
    chk("t2_pulse",  pulse_a, 1);
    chk("t2_ack_d",  ack_d,   0);
    chk("t2_ack_a",  ack_a,   1);
    chk("t2_ovf",    ovf_a,   0);

    // 3: overflow, sticky, clear, set-wins-over-clear
    toggle_i = 1'b1; repeat (4) tick();
    chk("t3_cnt_sat", cnt_a, 3);
    chk("t3_ovf_set", ovf_a, 1);
    chk("t3_ack_d",   ack_d, 1);
    repeat (3) tick();
    chk("t3_ovf_sticky", ovf_a, 1);
    clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;
    chk("t3_ovf_clr", ovf_a, 0);
    tick();
    chk("t3_ovf_stay0", ovf_a, 0);
    clr_ovf_i = 1'b1;
    toggle_i  = 1'b0;
    repeat (3) tick();
    chk("t3_set_wins", ovf_a, 1);
    chk("t3_cnt_hold", cnt_a, 3);
    clr_ovf_i = 1'b0;
    tick();
    chk("t3_ovf_held", ovf_a, 1);
    chk("t3_ack_d2",   ack_d, 0);

    // drain: three consecutive accepts
    ready_i = 1'b1;
    tick(); chk("dr_cnt2", cnt_a, 2); chk("dr_ack_a1", ack_a, 0);
    tick(); chk("dr_cnt1", cnt_a, 1); chk("dr_ack_a2", ack_a, 1);
    tick(); chk("dr_cnt0", cnt_a, 0); chk("dr_ack_a3", ack_a, 0);
    chk("dr_pulse", pulse_a, 0);
    chk("dr_ack_d", ack_d,   0);
    ready_i   = 1'b0;
    clr_ovf_i = 1'b1; tick(); clr_ovf_i = 1'b0;

    // 4: simultaneous arrival and accept at full
    toggle_i = 1'b1; repeat (4) tick();
    toggle_i = 1'b0; repeat (4) tick();
    toggle_i = 1'b1; repeat (4) tick();
    chk("t4_cnt_full", cnt_d, 3);
    chk("t4_ack_d0",   ack_d, 1);
    toggle_i = 1'b0;
    tick(); tick();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("t4_cnt",   cnt_a, 3);
    chk("t4_ovf",   ovf_a, 0);
    chk("t4_ack_a", ack_a, 1);
    chk("t4_ack_d", ack_d, 0);
    tick();
    chk("t4_cnt_after", cnt_a, 3);

    // 5: reset mid-operation with count 2
    ready_i = 1'b1; tick(); tick(); ready_i = 1'b0;
    chk("t5_cnt1", cnt_a, 1);
    chk("t5_ack_a", ack_a, 1);
    toggle_i = 1'b1; repeat (4) tick();
    chk("t5_cnt2",   cnt_a,   2);
    chk("t5_pulse1", pulse_a, 1);
    chk("t5_ack_d",  ack_d,   1);
    #2;
    rstn_b   = 1'b0;
    toggle_i = 1'b0;
    #1;
    chk("t5_rst_pulse", pulse_a, 0);
    chk("t5_rst_cnt",   cnt_a,   0);
    chk("t5_rst_ovf",   ovf_a,   0);
    chk("t5_rst_ack_a", ack_a,   0);
    chk("t5_rst_ack_d", ack_d,   0);
    rstn_b = 1'b1;
    repeat (5) tick();
    chk("t5_post_cnt",   cnt_a,   0);
    chk("t5_post_pulse", pulse_d, 0);

    // 6: ack-on-accept waits for the consumer
    toggle_i = 1'b1;
    repeat (3) tick();
    chk("t6_cnt1",  cnt_a, 1);
    chk("t6_ack_a", ack_a, 0);
    chk("t6_ack_d", ack_d, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t6_ack_wait", ack_a, 0);
    end
    ready_i = 1'b1;
    tick();
    chk("t6_ack_flip", ack_a, 1);
    chk("t6_cnt0",     cnt_a, 0);
    tick();
    chk("t6_ack_once", ack_a,   1);
    chk("t6_pulse0",   pulse_a, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
